// File: rtl/sub_bus_vram_pkg.sv
// Shared definitions for the bus-programmed VRAM rectangle fill block:
// register indices, CTRL/STATUS bit positions, FSM encoding and fill geometry.
package sub_bus_vram_pkg;

  localparam logic [2:0] REG_X0    = 3'd0;
  localparam logic [2:0] REG_Y0    = 3'd1;
  localparam logic [2:0] REG_W     = 3'd2;
  localparam logic [2:0] REG_H     = 3'd3;
  localparam logic [2:0] REG_COLOR = 3'd4;
  localparam logic [2:0] REG_BASE  = 3'd5;
  localparam logic [2:0] REG_CTRL  = 3'd6;
  localparam logic [2:0] REG_COUNT = 3'd7;

  localparam int CTRL_START_BIT     = 0;
  localparam int CTRL_ABORT_BIT     = 1;
  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_DONE_BIT    = 1;
  localparam int STATUS_ABORTED_BIT = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [15:0] base;
    logic [8:0]  h;
    logic [8:0]  w;
    logic [7:0]  y0;
    logic [7:0]  x0;
  } fill_rect_t;

  // A rectangle never spans more than one full 256-pixel row or column.
  function automatic logic [8:0] saturate_dim(input logic [15:0] value);
    if (value > 16'd256) begin
      return 9'd256;
    end
    return value[8:0];
  endfunction

endpackage

// File: rtl/sub_bus_rw_vram_fill_if.sv
// Bus and VRAM write-port signals of the fill block; slave is the block side.
interface sub_bus_rw_vram_fill_if;
  logic        i_bus_we;
  logic        i_bus_addr;
  logic [15:0] i_bus_data_write;
  logic [15:0] o_bus_data_read;
  logic [15:0] o_vram_addr;
  logic [3:0]  o_vram_data;
  logic        o_vram_we;
  logic        i_vram_ready;

  modport slave (
    input  i_bus_we, i_bus_addr, i_bus_data_write, i_vram_ready,
    output o_bus_data_read, o_vram_addr, o_vram_data, o_vram_we
  );

  modport master (
    output i_bus_we, i_bus_addr, i_bus_data_write, i_vram_ready,
    input  o_bus_data_read, o_vram_addr, o_vram_data, o_vram_we
  );
endinterface

// File: rtl/sub_bus_rw_vram_fill_walker.sv
// Walks a latched rectangle row by row and forms BASE + {y, x}, with x and y
// wrapping inside the 256x256 page.
module vram_rect_walker
  import sub_bus_vram_pkg::*;
(
  input  logic        bus_clock,
  input  logic        reset,
  input  logic        load,
  input  fill_rect_t  rect_load,
  input  logic        step,
  output logic        last,
  output logic [15:0] addr
);

  fill_rect_t  rect_reg;
  logic [7:0]  col_reg, col_next;
  logic [7:0]  row_reg, row_next;
  logic        col_end, row_end;
  logic [7:0]  x_pos, y_pos;

  assign col_end = ({1'b0, col_reg} == rect_reg.w - 9'd1);
  assign row_end = ({1'b0, row_reg} == rect_reg.h - 9'd1);
  assign last    = col_end && row_end;

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (load) begin
      col_next = 8'd0;
      row_next = 8'd0;
    end else if (step) begin
      if (col_end) begin
        col_next = 8'd0;
        row_next = row_reg + 8'd1;
      end else begin
        col_next = col_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge bus_clock) begin
    if (!reset) begin
      rect_reg <= '0;
      col_reg  <= '0;
      row_reg  <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
      if (load) begin
        rect_reg <= rect_load;
      end
    end
  end

  assign x_pos = rect_reg.x0 + col_reg;
  assign y_pos = rect_reg.y0 + row_reg;
  assign addr  = rect_reg.base + {y_pos, x_pos};

endmodule

// File: rtl/sub_bus_rw_vram_fill.sv
// Bus-programmed rectangle fill engine: an index/data register window sets up
// a rectangle that is then written pixel by pixel to VRAM with ready handshake.
module sub_bus_rw_vram_fill
  import sub_bus_vram_pkg::*;
#(
  parameter logic [15:0] VRAM_BASE_DEFAULT  = 16'h0000,
  parameter logic [3:0]  FILL_COLOR_DEFAULT = 4'h0
) (
  input logic                   bus_clock,
  input logic                   reset,
  sub_bus_rw_vram_fill_if.slave bus
);

  logic [1:0]  state_reg, state_next;
  logic [2:0]  index_reg;
  logic [7:0]  x0_reg, y0_reg;
  logic [8:0]  w_reg, h_reg;
  logic [3:0]  color_reg, color_work_reg;
  logic [15:0] base_reg;
  logic        busy_reg, done_reg, aborted_reg;
  logic [15:0] count_reg;
  logic [15:0] read_data_reg, read_data_next;

  logic        wr_index, wr_data;
  logic [7:0]  reg_sel;
  logic        start_req, abort_req, do_start, do_abort;
  logic        rect_empty, accept, walk_last;
  logic [15:0] walk_addr, status_word, reg_rdata;
  fill_rect_t  rect_now;

  assign wr_index = bus.i_bus_we && !bus.i_bus_addr;
  assign wr_data  = bus.i_bus_we && bus.i_bus_addr;

  for (genvar gi = 0; gi < 8; gi++) begin : g_reg_sel
    assign reg_sel[gi] = wr_data && (index_reg == 3'(gi));
  end

  // Abort wins when both CTRL bits are written together.
  assign start_req = reg_sel[REG_CTRL] && bus.i_bus_data_write[CTRL_START_BIT]
                     && !bus.i_bus_data_write[CTRL_ABORT_BIT];
  assign abort_req = reg_sel[REG_CTRL] && bus.i_bus_data_write[CTRL_ABORT_BIT];
  assign do_start  = start_req && (state_reg == ST_IDLE);
  assign do_abort  = abort_req && (state_reg == ST_FILL);

  assign rect_empty = (w_reg == 9'd0) || (h_reg == 9'd0);
  assign accept     = (state_reg == ST_FILL) && bus.i_vram_ready;

  always_comb begin
    rect_now      = '0;
    rect_now.x0   = x0_reg;
    rect_now.y0   = y0_reg;
    rect_now.w    = w_reg;
    rect_now.h    = h_reg;
    rect_now.base = base_reg;
  end

  vram_rect_walker u_walker (
    .bus_clock (bus_clock),
    .reset     (reset),
    .load      (do_start && !rect_empty),
    .rect_load (rect_now),
    .step      (accept),
    .last      (walk_last),
    .addr      (walk_addr)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (do_start) state_next = rect_empty ? ST_DONE : ST_FILL;
      ST_FILL: begin
        if (do_abort) begin
          state_next = ST_IDLE;
        end else if (accept && walk_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge bus_clock) begin
    if (!reset) begin
      index_reg <= '0;
      x0_reg    <= '0;
      y0_reg    <= '0;
      w_reg     <= '0;
      h_reg     <= '0;
      color_reg <= FILL_COLOR_DEFAULT;
      base_reg  <= VRAM_BASE_DEFAULT;
    end else begin
      if (wr_index)            index_reg <= bus.i_bus_data_write[2:0];
      if (reg_sel[REG_X0])     x0_reg    <= bus.i_bus_data_write[7:0];
      if (reg_sel[REG_Y0])     y0_reg    <= bus.i_bus_data_write[7:0];
      if (reg_sel[REG_W])      w_reg     <= saturate_dim(bus.i_bus_data_write);
      if (reg_sel[REG_H])      h_reg     <= saturate_dim(bus.i_bus_data_write);
      if (reg_sel[REG_COLOR])  color_reg <= bus.i_bus_data_write[3:0];
      if (reg_sel[REG_BASE])   base_reg  <= bus.i_bus_data_write;
    end
  end

  always_ff @(posedge bus_clock) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      aborted_reg    <= 1'b0;
      count_reg      <= '0;
      color_work_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (do_start) begin
        busy_reg       <= !rect_empty;
        done_reg       <= rect_empty;
        aborted_reg    <= 1'b0;
        count_reg      <= '0;
        color_work_reg <= color_reg;
      end else begin
        // A pixel accepted on the abort edge still counts.
        if (accept) count_reg <= count_reg + 16'd1;
        if (do_abort) begin
          busy_reg    <= 1'b0;
          aborted_reg <= 1'b1;
        end else if (accept && walk_last) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    status_word                     = '0;
    status_word[STATUS_BUSY_BIT]    = busy_reg;
    status_word[STATUS_DONE_BIT]    = done_reg;
    status_word[STATUS_ABORTED_BIT] = aborted_reg;
  end

  always_comb begin
    reg_rdata = '0;
    case (index_reg)
      REG_X0:    reg_rdata = {8'h00, x0_reg};
      REG_Y0:    reg_rdata = {8'h00, y0_reg};
      REG_W:     reg_rdata = {7'h00, w_reg};
      REG_H:     reg_rdata = {7'h00, h_reg};
      REG_COLOR: reg_rdata = {12'h000, color_reg};
      REG_BASE:  reg_rdata = base_reg;
      REG_CTRL:  reg_rdata = status_word;
      REG_COUNT: reg_rdata = count_reg;
      default:   reg_rdata = '0;
    endcase
  end

  assign read_data_next = bus.i_bus_addr ? reg_rdata : {13'h0000, index_reg};

  always_ff @(posedge bus_clock) begin
    if (!reset) begin
      read_data_reg <= '0;
    end else begin
      read_data_reg <= read_data_next;
    end
  end

  assign bus.o_bus_data_read = read_data_reg;
  assign bus.o_vram_we       = (state_reg == ST_FILL);
  assign bus.o_vram_addr     = walk_addr;
  assign bus.o_vram_data     = color_work_reg;

endmodule

// File: tb/tb_sub_bus_rw_vram_fill.sv
// Directed bench for the VRAM fill block: register map, fill patterns,
// handshake stalls, abort, zero-size start and reset behaviour.
module tb_sub_bus_rw_vram_fill;

  logic bus_clock = 1'b0;
  logic reset;
  always #5 bus_clock = ~bus_clock;

  sub_bus_rw_vram_fill_if bus_if ();

  sub_bus_rw_vram_fill #(
    .VRAM_BASE_DEFAULT  (16'h1234),
    .FILL_COLOR_DEFAULT (4'hA)
  ) dut (
    .bus_clock (bus_clock),
    .reset     (reset),
    .bus       (bus_if)
  );

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;
  int ph = 0;
  bit hold_valid = 1'b0;
  logic [15:0] hold_addr;
  logic [3:0]  hold_data;
  logic [15:0] acc_addr[$];
  logic [3:0]  acc_data[$];
  logic [15:0] exp_addr[$];
  logic [15:0] rd;
  int n_acc;
  int lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Accepted-pixel recorder plus stall stability check.
  always @(negedge bus_clock) begin
    if (bus_if.o_vram_we === 1'b1) begin
      if (hold_valid) begin
        chk("hold_addr", bus_if.o_vram_addr, hold_addr);
        chk("hold_data", bus_if.o_vram_data, hold_data);
      end
      if (bus_if.i_vram_ready) begin
        acc_addr.push_back(bus_if.o_vram_addr);
        acc_data.push_back(bus_if.o_vram_data);
        $display("pixel addr=0x%04h data=0x%0h", bus_if.o_vram_addr, bus_if.o_vram_data);
        hold_valid = 1'b0;
        ph = 0;
      end else begin
        hold_valid = 1'b1;
        hold_addr  = bus_if.o_vram_addr;
        hold_data  = bus_if.o_vram_data;
        ph++;
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  always @(posedge bus_clock) begin
    #1;
    bus_if.i_vram_ready = (rdy_mode == 0) || (ph == 2);
  end

  task automatic bus_write(input logic a, input logic [15:0] d);
    @(negedge bus_clock);
    bus_if.i_bus_we         = 1'b1;
    bus_if.i_bus_addr       = a;
    bus_if.i_bus_data_write = d;
    @(negedge bus_clock);
    bus_if.i_bus_we = 1'b0;
  endtask

  task automatic reg_write(input logic [2:0] idx, input logic [15:0] val);
    bus_write(1'b0, {13'h0, idx});
    bus_write(1'b1, val);
  endtask

  task automatic reg_read(input logic [2:0] idx, output logic [15:0] val);
    bus_write(1'b0, {13'h0, idx});
    bus_if.i_bus_addr = 1'b1;
    @(negedge bus_clock);
    val = bus_if.o_bus_data_read;
  endtask

  task automatic clear_acc();
    acc_addr.delete();
    acc_data.delete();
    exp_addr.delete();
  endtask

  task automatic start_fill();
    bus_write(1'b0, 16'd6);
    clear_acc();
    bus_write(1'b1, 16'h0001);
  endtask

  task automatic wait_fill_end();
    for (int i = 0; i < 3000; i++) begin
      if (!bus_if.o_vram_we) break;
      @(negedge bus_clock);
    end
    chk("fill_end", bus_if.o_vram_we, 1'b0);
    @(negedge bus_clock);
  endtask

  task automatic check_fill(input string tag, input logic [3:0] color);
    chk({tag, "_n"}, acc_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < acc_addr.size(); i++) begin
      chk({tag, "_addr"}, acc_addr[i], exp_addr[i]);
      chk({tag, "_data"}, acc_data[i], color);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus_if.i_bus_we = 1'b0;
    bus_if.i_bus_addr = 1'b0;
    bus_if.i_bus_data_write = 16'h0;
    bus_if.i_vram_ready = 1'b1;
    repeat (3) @(negedge bus_clock);
    chk("rst_we", bus_if.o_vram_we, 1'b0);
    chk("rst_vaddr", bus_if.o_vram_addr, 16'h0);
    chk("rst_vdata", bus_if.o_vram_data, 4'h0);
    chk("rst_rdata", bus_if.o_bus_data_read, 16'h0);
    reset = 1'b1;
    @(negedge bus_clock);
    chk("rst_index", bus_if.o_bus_data_read, 16'h0);
    reg_read(3'd4, rd); chk("rst_color", rd, 16'h000A);
    reg_read(3'd5, rd); chk("rst_base", rd, 16'h1234);
    reg_read(3'd2, rd); chk("rst_w", rd, 16'h0);
    reg_read(3'd6, rd); chk("rst_status", rd, 16'h0);
    reg_read(3'd7, rd); chk("rst_count", rd, 16'h0);

    // Basic 3x2 fill with latency measurement.
    reg_write(3'd0, 16'd2); reg_write(3'd1, 16'd3); reg_write(3'd2, 16'd3);
    reg_write(3'd3, 16'd2); reg_write(3'd4, 16'd5); reg_write(3'd5, 16'h0000);
    start_fill();
    chk("first_we", bus_if.o_vram_we, 1'b1);
    lat = -1;
    for (int k = 1; k < 100; k++) begin
      @(negedge bus_clock);
      if (bus_if.o_bus_data_read[0] == 1'b0) begin
        lat = k;
        break;
      end
    end
    chk("busy_latency", lat, 7);
    exp_addr = '{16'h0302, 16'h0303, 16'h0304, 16'h0402, 16'h0403, 16'h0404};
    check_fill("rect3x2", 4'h5);
    reg_read(3'd7, rd); chk("rect3x2_count", rd, 16'd6);
    reg_read(3'd6, rd); chk("rect3x2_status", rd, 16'h0002);

    // Register map details.
    reg_write(3'd2, 16'h0200); reg_read(3'd2, rd); chk("w_sat_512", rd, 16'h0100);
    reg_write(3'd2, 16'h0101); reg_read(3'd2, rd); chk("w_sat_257", rd, 16'h0100);
    reg_write(3'd3, 16'h0100); reg_read(3'd3, rd); chk("h_256", rd, 16'h0100);
    reg_write(3'd4, 16'hFFF7); reg_read(3'd4, rd); chk("color_mask", rd, 16'h0007);
    reg_write(3'd0, 16'hABCD); reg_read(3'd0, rd); chk("x0_mask", rd, 16'h00CD);
    reg_write(3'd7, 16'h5555); reg_read(3'd7, rd); chk("count_ro", rd, 16'd6);
    bus_write(1'b0, 16'hFFFD);
    @(negedge bus_clock);
    chk("index_read", bus_if.o_bus_data_read, 16'h0005);

    // x wraps inside the row.
    reg_write(3'd0, 16'd254); reg_write(3'd1, 16'd0); reg_write(3'd2, 16'd4);
    reg_write(3'd3, 16'd1); reg_write(3'd4, 16'd3);
    start_fill(); wait_fill_end();
    exp_addr = '{16'h00FE, 16'h00FF, 16'h0000, 16'h0001};
    check_fill("xwrap", 4'h3);

    // Address adder wraps at 2^16.
    reg_write(3'd0, 16'd0); reg_write(3'd2, 16'd2); reg_write(3'd5, 16'hFFFF);
    start_fill(); wait_fill_end();
    exp_addr = '{16'hFFFF, 16'h0000};
    check_fill("basewrap", 4'h3);

    // Stalled handshake: ready 0,0,1 per pixel.
    reg_write(3'd0, 16'd10); reg_write(3'd1, 16'd20); reg_write(3'd2, 16'd2);
    reg_write(3'd3, 16'd2); reg_write(3'd4, 16'd9); reg_write(3'd5, 16'h1000);
    rdy_mode = 1;
    start_fill(); wait_fill_end();
    rdy_mode = 0;
    exp_addr = '{16'h240A, 16'h240B, 16'h250A, 16'h250B};
    check_fill("stall", 4'h9);
    reg_read(3'd7, rd); chk("stall_count", rd, 16'd4);

    // 100-pixel fill; a second start and a COLOR write while busy.
    reg_write(3'd0, 16'd0); reg_write(3'd1, 16'd0); reg_write(3'd2, 16'd10);
    reg_write(3'd3, 16'd10); reg_write(3'd4, 16'd1); reg_write(3'd5, 16'h0000);
    start_fill();
    repeat (3) @(negedge bus_clock);
    reg_write(3'd4, 16'd7);
    bus_write(1'b0, 16'd6);
    bus_write(1'b1, 16'h0001);
    wait_fill_end();
    chk("big_n", acc_addr.size(), 100);
    if (acc_addr.size() == 100) begin
      chk("big_addr10", acc_addr[10], 16'h0100);
      chk("big_addr99", acc_addr[99], 16'h0909);
      for (int i = 0; i < 100; i++) chk("big_data", acc_data[i], 4'h1);
    end
    reg_read(3'd7, rd); chk("big_count", rd, 16'd100);
    reg_read(3'd6, rd); chk("big_status", rd, 16'h0002);

    // Abort on the edge of the 4th accept.
    start_fill();
    repeat (2) @(negedge bus_clock);
    bus_write(1'b1, 16'h0002);
    chk("abort_we", bus_if.o_vram_we, 1'b0);
    repeat (2) @(negedge bus_clock);
    exp_addr = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
    check_fill("abort", 4'h7);
    reg_read(3'd6, rd); chk("abort_status", rd, 16'h0004);
    reg_read(3'd7, rd); chk("abort_count", rd, 16'd4);

    // Zero-width start goes straight to DONE.
    reg_write(3'd2, 16'd0); reg_write(3'd3, 16'd5);
    start_fill();
    chk("w0_we0", bus_if.o_vram_we, 1'b0);
    @(negedge bus_clock);
    chk("w0_status", bus_if.o_bus_data_read, 16'h0002);
    chk("w0_we1", bus_if.o_vram_we, 1'b0);
    repeat (3) @(negedge bus_clock);
    chk("w0_n", acc_addr.size(), 0);
    reg_read(3'd7, rd); chk("w0_count", rd, 16'd0);

    // Abort in IDLE and start+abort together do nothing.
    reg_write(3'd2, 16'd2); reg_write(3'd3, 16'd2);
    bus_write(1'b0, 16'd6);
    bus_write(1'b1, 16'h0002);
    reg_read(3'd6, rd); chk("idle_abort", rd, 16'h0002);
    bus_write(1'b0, 16'd6);
    clear_acc();
    bus_write(1'b1, 16'h0003);
    repeat (3) @(negedge bus_clock);
    chk("start_abort_n", acc_addr.size(), 0);
    reg_read(3'd6, rd); chk("start_abort_status", rd, 16'h0002);

    // Reset in the middle of a fill.
    reg_write(3'd2, 16'd10); reg_write(3'd3, 16'd10);
    start_fill();
    repeat (3) @(negedge bus_clock);
    reset = 1'b0;
    @(negedge bus_clock);
    chk("mid_rst_we", bus_if.o_vram_we, 1'b0);
    chk("mid_rst_vaddr", bus_if.o_vram_addr, 16'h0);
    chk("mid_rst_vdata", bus_if.o_vram_data, 4'h0);
    chk("mid_rst_rdata", bus_if.o_bus_data_read, 16'h0);
    n_acc = acc_addr.size();
    bus_if.i_bus_addr = 1'b0;
    reset = 1'b1;
    @(negedge bus_clock);
    chk("mid_rst_index", bus_if.o_bus_data_read, 16'h0);
    repeat (5) @(negedge bus_clock);
    chk("mid_rst_nowrite", acc_addr.size(), n_acc);
    reg_read(3'd6, rd); chk("mid_rst_status", rd, 16'h0);
    reg_read(3'd7, rd); chk("mid_rst_count", rd, 16'h0);
    reg_read(3'd4, rd); chk("mid_rst_color", rd, 16'h000A);
    reg_read(3'd5, rd); chk("mid_rst_base", rd, 16'h1234);
    reg_read(3'd2, rd); chk("mid_rst_w", rd, 16'h0);
    reg_read(3'd0, rd); chk("mid_rst_x0", rd, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
